// File: rtl/varredura_matriz.sv
// ---------------------------------------------------------------------------
// varredura_matriz
//
// Row-scanning driver for an 8x8 LED matrix. Each row passes through three
// phases:
//   BLANK : all rows off; row_addr presents the row index to frame memory.
//   LOAD  : one cycle; the column pattern returned by memory is captured.
//   SHOW  : the row is driven (active-low) with the captured columns.
// Row period = BLANK_CYCLES + 1 + DIV cycles, frame period = 8 row periods.
//
// Parameters:
//   DIV          SHOW-phase length in cycles per row (>= 8; a multiple of 8
//                when DIMMING_EN is defined).
//   BLANK_CYCLES BLANK-phase length in cycles (>= 1).
//
// Optional feature (macro DIMMING_EN):
//   Adds input brilho[2:0], sampled in LOAD. SHOW is split into 8 slices of
//   DIV/8 cycles and the row is lit only in slices 0..brilho. The SHOW length
//   does not change, so the row period is the same with or without dimming.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high; wins over everything
//   enable      in   level-sensitive run request; 0 forces IDLE next cycle
//   row_data    in   [7:0] column pattern for row_addr (one cycle latency)
//   brilho      in   [2:0] brightness (only with DIMMING_EN)
//   row_addr    out  [2:0] frame-memory address = current row index
//   row_n       out  [7:0] row drivers, active-low, at most one low bit
//   cols        out  [7:0] column drivers, active-high
//   frame_done  out  one-cycle pulse after row 7 finishes
//   dbg_state   out  [1:0] FSM state (IDLE=0, BLANK=1, LOAD=2, SHOW=3)
//
// Handshake: there is no valid/ready pair here. row_data is treated as a
// plain synchronous read port: it must reflect row_addr one cycle after
// row_addr became stable. row_addr is stable for the whole BLANK phase, so
// capturing row_data at the end of LOAD always sees the correct row.
//
// All outputs are registers. The combinational process computes the value
// every register takes at the next edge; row_n is derived from the next
// state so that it changes on the same edge as the state itself.
// ---------------------------------------------------------------------------
module varredura_matriz #(
  parameter int DIV          = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] row_data,
`ifdef DIMMING_EN
  input  logic [2:0] brilho,
`endif
  output logic [2:0] row_addr,
  output logic [7:0] row_n,
  output logic [7:0] cols,
  output logic       frame_done,
  output logic [1:0] dbg_state
);

  // Counter must hold the larger of the two phase lengths.
  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    LOAD  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_row;
  logic [7:0]      r_cols;
  logic [7:0]      r_row_n;
  logic            r_frame_done;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2:0]      w_row_nxt;
  logic [7:0]      w_cols_nxt;
  logic [7:0]      w_row_n_nxt;
  logic            w_frame_done_nxt;
  logic            w_lit;

`ifdef DIMMING_EN
  // Slice bookkeeping for the dimmed SHOW phase. r_sub counts down the
  // cycles left in the current slice, r_slice is the slice number 0..7.
  localparam int SLICE = DIV / 8;
  localparam int SW    = (SLICE > 1) ? $clog2(SLICE) : 1;

  logic [2:0]    r_brilho;
  logic [2:0]    r_slice;
  logic [SW-1:0] r_sub;

  logic [2:0]    w_brilho_nxt;
  logic [2:0]    w_slice_nxt;
  logic [SW-1:0] w_sub_nxt;
`endif

  // -------------------------------------------------------------------------
  // Sequential process: state register plus registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_cols       <= 8'h00;
      r_row_n      <= 8'hFF;
      r_frame_done <= 1'b0;
`ifdef DIMMING_EN
      r_brilho     <= '0;
      r_slice      <= '0;
      r_sub        <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_row        <= w_row_nxt;
      r_cols       <= w_cols_nxt;
      r_row_n      <= w_row_n_nxt;
      r_frame_done <= w_frame_done_nxt;
`ifdef DIMMING_EN
      r_brilho     <= w_brilho_nxt;
      r_slice      <= w_slice_nxt;
      r_sub        <= w_sub_nxt;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Combinational process: next state and next output values
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_row_nxt        = r_row;
    w_cols_nxt       = r_cols;
    w_frame_done_nxt = 1'b0;
    w_row_n_nxt      = 8'hFF;
    w_lit            = 1'b0;
`ifdef DIMMING_EN
    w_brilho_nxt     = r_brilho;
    w_slice_nxt      = r_slice;
    w_sub_nxt        = r_sub;
`endif

    if (!enable) begin
      // Dropping enable abandons whatever phase is running.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_row_nxt   = 3'd0;
      w_cols_nxt  = 8'h00;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = CW'(BLANK_CYCLES - 1);
          w_cols_nxt  = 8'h00;
        end

        BLANK: begin
          if (r_cnt == '0) begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
          end
        end

        LOAD: begin
          w_state_nxt  = SHOW;
          w_cnt_nxt    = CW'(DIV - 1);
          w_cols_nxt   = row_data;
`ifdef DIMMING_EN
          // Brightness is frozen for the whole row; later changes apply
          // from the next LOAD.
          w_brilho_nxt = brilho;
          w_slice_nxt  = 3'd0;
          w_sub_nxt    = SW'(SLICE - 1);
`endif
        end

        SHOW: begin
          if (r_cnt == '0) begin
            w_state_nxt      = BLANK;
            w_cnt_nxt        = CW'(BLANK_CYCLES - 1);
            w_row_nxt        = r_row + 3'd1;  // 7 wraps to 0
            w_cols_nxt       = 8'h00;
            // Pulse lands in the first BLANK cycle after row 7.
            w_frame_done_nxt = (r_row == 3'd7);
          end else begin
            w_cnt_nxt        = r_cnt - CW'(1);
          end
`ifdef DIMMING_EN
          if (r_sub == '0) begin
            w_slice_nxt = r_slice + 3'd1;
            w_sub_nxt   = SW'(SLICE - 1);
          end else begin
            w_sub_nxt   = r_sub - SW'(1);
          end
`endif
        end

        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_row_nxt   = 3'd0;
          w_cols_nxt  = 8'h00;
        end
      endcase
    end

    // Row drive is derived from the next state so it moves on the same edge
    // as the FSM; LOAD and BLANK always keep every row off, which gives at
    // least BLANK_CYCLES dark cycles between any two lit rows.
`ifdef DIMMING_EN
    w_lit = (w_slice_nxt <= w_brilho_nxt);
`else
    w_lit = 1'b1;
`endif
    if ((w_state_nxt == SHOW) && w_lit) begin
      w_row_n_nxt = ~(8'd1 << w_row_nxt);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign row_addr   = r_row;
  assign row_n      = r_row_n;
  assign cols       = r_cols;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

endmodule
